accelerator_vector_integer_summation: RTL

- Downstream stage of the vector integer multiplier.
- Consumes its element stream (DATA_OUT qualified by DATA_OUT_ENABLE) and reduces SIZE_IN elements to one scalar sum. The multiplier followed by this block forms a vector dot product.
- Unsigned modulo-2^DATA_SIZE accumulation with a carry-out counter reported on OVERFLOW_OUT.

---
 rtl/accelerator_vector_integer_summation.sv | 86 ++++++++
 1 files changed

// File: rtl/accelerator_vector_integer_summation.sv
// Reduces SIZE_IN elements to one sum mod 2^DATA_SIZE and counts carry-outs; result is registered one cycle after the last element.
// Never stalls upstream: one element per cycle is accepted, and DATA_IN_ENABLE gaps simply hold state.
module accelerator_vector_integer_summation #(
  parameter int DATA_SIZE    = 64,
  parameter int CONTROL_SIZE = 64
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 START,
  output logic                 READY,
  input  logic                 DATA_IN_ENABLE,
  output logic                 DATA_OUT_ENABLE,
  input  logic [DATA_SIZE-1:0] SIZE_IN,
  input  logic [DATA_SIZE-1:0] DATA_IN,
  output logic [DATA_SIZE-1:0] DATA_OUT,
  output logic [DATA_SIZE-1:0] OVERFLOW_OUT
);

  localparam logic [1:0] STARTER_STATE = 2'd0;
  localparam logic [1:0] INPUT_STATE   = 2'd1;
  localparam logic [1:0] ENDER_STATE   = 2'd2;

  localparam int CMP_W = (CONTROL_SIZE > DATA_SIZE) ? CONTROL_SIZE : DATA_SIZE;

  logic [1:0]              state;
  logic [DATA_SIZE-1:0]    acc;
  logic [DATA_SIZE-1:0]    ovf_cnt;
  logic [DATA_SIZE-1:0]    size_reg;
  logic [CONTROL_SIZE-1:0] idx;

  logic [DATA_SIZE:0]      sum_full;
  logic [DATA_SIZE-1:0]    last_idx;
  logic [CMP_W-1:0]        idx_cmp;
  logic [CMP_W-1:0]        last_cmp;

  // Index and size may differ in width, so compare them zero-extended.
  assign sum_full = {1'b0, acc} + {1'b0, DATA_IN};
  assign last_idx = size_reg - DATA_SIZE'(1);
  assign idx_cmp  = CMP_W'(idx);
  assign last_cmp = CMP_W'(last_idx);

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state           <= STARTER_STATE;
      acc             <= '0;
      ovf_cnt         <= '0;
      size_reg        <= '0;
      idx             <= '0;
      READY           <= 1'b0;
      DATA_OUT_ENABLE <= 1'b0;
      DATA_OUT        <= '0;
      OVERFLOW_OUT    <= '0;
    end else begin
      READY           <= 1'b0;
      DATA_OUT_ENABLE <= 1'b0;
      case (state)
        STARTER_STATE: begin
          if (START) begin
            acc      <= '0;
            ovf_cnt  <= '0;
            idx      <= '0;
            size_reg <= SIZE_IN;
            state    <= (SIZE_IN == '0) ? ENDER_STATE : INPUT_STATE;
          end
        end
        INPUT_STATE: begin
          if (DATA_IN_ENABLE) begin
            acc <= sum_full[DATA_SIZE-1:0];
            if (sum_full[DATA_SIZE]) ovf_cnt <= ovf_cnt + DATA_SIZE'(1);
            if (idx_cmp == last_cmp) state <= ENDER_STATE;
            else                     idx   <= idx + CONTROL_SIZE'(1);
          end
        end
        ENDER_STATE: begin
          DATA_OUT        <= acc;
          OVERFLOW_OUT    <= ovf_cnt;
          READY           <= 1'b1;
          DATA_OUT_ENABLE <= 1'b1;
          state           <= STARTER_STATE;
        end
        default: state <= STARTER_STATE;
      endcase
    end
  end

endmodule
